// File: rtl/alu74181_io_stage_if.sv
// Signal bundle between the pad/ALU environment and the 74181 IO stage.
// master is the stage itself; slave is the pads plus the ALU core.
interface alu74181_io_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic [13:0]      io_in;
  logic             alu_m;
  logic             alu_cn;
  logic [3:0]       alu_s;
  logic [3:0]       alu_b;
  logic [3:0]       alu_a;
  logic             alu_start;
  logic [7:0]       alu_result;
  logic [7:0]       io_out;
  logic [7:0]       io_oeb;
  logic             result_valid;
  logic [CNT_W-1:0] op_count;

  modport master (
    input  io_in,
    input  alu_result,
    output alu_m,
    output alu_cn,
    output alu_s,
    output alu_b,
    output alu_a,
    output alu_start,
    output io_out,
    output io_oeb,
    output result_valid,
    output op_count
  );

  modport slave (
    output io_in,
    output alu_result,
    input  alu_m,
    input  alu_cn,
    input  alu_s,
    input  alu_b,
    input  alu_a,
    input  alu_start,
    input  io_out,
    input  io_oeb,
    input  result_valid,
    input  op_count
  );
endinterface

// File: rtl/alu74181_io_stage.sv
// Pad-side front end for a 74181 ALU: debounces the operand bus, issues it to the
// ALU, waits a fixed latency and publishes the result with valid/oeb/count.
module alu74181_io_stage #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ALU_LAT       = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  alu74181_io_stage_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StIssue,
    StWait,
    StPublish
  } state_e;

  localparam logic [7:0] CntLast  = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0] WaitLast = (ALU_LAT == 0) ? 4'd0 : 4'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] CountOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [13:0]      sync_q;
  logic [13:0]      io_sync_q;
  logic [13:0]      ref_q, ref_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [13:0]      opnd_q, opnd_d;
  logic [13:0]      last_q, last_d;
  logic             applied_valid_q, applied_valid_d;
  logic [7:0]       io_out_q, io_out_d;
  logic [7:0]       io_oeb_q, io_oeb_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             sample;

  // Two-flop synchroniser; nothing downstream looks at raw io_in.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q    <= '0;
      io_sync_q <= '0;
    end else begin
      sync_q    <= bus.io_in;
      io_sync_q <= sync_q;
    end
  end

  always_comb begin
    state_d         = state_q;
    ref_d           = ref_q;
    cnt_d           = cnt_q;
    wcnt_d          = wcnt_q;
    opnd_d          = opnd_q;
    last_d          = last_q;
    applied_valid_d = applied_valid_q;
    io_out_d        = io_out_q;
    io_oeb_d        = io_oeb_q;
    op_count_d      = op_count_q;
    sample          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!applied_valid_q || (io_sync_q != last_q)) begin
          state_d = StSettle;
          ref_d   = io_sync_q;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (io_sync_q != ref_q) begin
          ref_d = io_sync_q;
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIssue;
          opnd_d  = ref_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StIssue: begin
        if (ALU_LAT == 0) begin
          sample = 1'b1;
        end else begin
          state_d = StWait;
          wcnt_d  = '0;
        end
      end
      StWait: begin
        if (wcnt_q == WaitLast) begin
          sample = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      StPublish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Result capture and all publish bookkeeping happen on the edge entering StPublish.
    if (sample) begin
      state_d         = StPublish;
      io_out_d        = bus.alu_result;
      op_count_d      = op_count_q + CountOne;
      last_d          = opnd_q;
      applied_valid_d = 1'b1;
      io_oeb_d        = 8'h00;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q         <= StIdle;
      ref_q           <= '0;
      cnt_q           <= '0;
      wcnt_q          <= '0;
      opnd_q          <= '0;
      last_q          <= '0;
      applied_valid_q <= 1'b0;
      io_out_q        <= '0;
      io_oeb_q        <= 8'hFF;
      op_count_q      <= '0;
    end else begin
      state_q         <= state_d;
      ref_q           <= ref_d;
      cnt_q           <= cnt_d;
      wcnt_q          <= wcnt_d;
      opnd_q          <= opnd_d;
      last_q          <= last_d;
      applied_valid_q <= applied_valid_d;
      io_out_q        <= io_out_d;
      io_oeb_q        <= io_oeb_d;
      op_count_q      <= op_count_d;
    end
  end

  assign bus.alu_m        = opnd_q[13];
  assign bus.alu_cn       = opnd_q[12];
  assign bus.alu_s        = opnd_q[11:8];
  assign bus.alu_b        = opnd_q[7:4];
  assign bus.alu_a        = opnd_q[3:0];
  assign bus.alu_start    = (state_q == StIssue);
  assign bus.result_valid = (state_q == StPublish);
  assign bus.io_out       = io_out_q;
  assign bus.io_oeb       = io_oeb_q;
  assign bus.op_count     = op_count_q;

endmodule
